univ_shift_reg_burst: RTL and testbench

Parametrised universal shift register with an 8-operation mode set and a multi-cycle burst engine.
- Direct mode: one operation per enabled clock.
- Burst mode: on start, a latched operation repeats count times, with busy/done/abort handshake and a remaining-count readout.
- Encodings 000-011 match the team's 2-bit universal shift register, so existing control logic ports over unchanged.
- Sits in datapath serialisers and bit-manipulation units.

---
 rtl/usr_pkg.sv | 28 ++
 rtl/usr_next_val.sv | 40 ++++
 rtl/univ_shift_reg_burst.sv | 136 +++++++++++++
 tb/tb_univ_shift_reg_burst.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
//------------------------------------------------------------------------------
// Module : usr_pkg
// Brief  : Shared operation encodings and FSM state type for the universal
//          shift register with burst engine.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package usr_pkg;

  // Encodings 000-011 are identical to the 2-bit universal shift register.
  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_HOLD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/usr_next_val.sv
//------------------------------------------------------------------------------
// Module : usr_next_val
// Brief  : Combinational next-value function for all eight operations; shared
//          by the direct path and the burst path.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module usr_next_val
  import usr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]    mode,
  input  logic [DW-1:0] q,
  input  logic [DW-1:0] data,
  input  logic          data_l,
  input  logic          data_h,
  output logic [DW-1:0] q_next
);

  // Select the new register value for the requested operation.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_LOAD: q_next = data;
      MODE_SHR:  q_next = {data_h, q[DW-1:1]};
      MODE_SHL:  q_next = {q[DW-2:0], data_l};
      MODE_HOLD: q_next = q;
      MODE_ROR:  q_next = {q[0], q[DW-1:1]};
      MODE_ROL:  q_next = {q[DW-2:0], q[DW-1]};
      MODE_ASR:  q_next = {q[DW-1], q[DW-1:1]};
      MODE_CLR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg_burst.sv
//------------------------------------------------------------------------------
// Module : univ_shift_reg_burst
// Brief  : Universal shift register, one operation per enabled clock in
//          direct mode, or a latched operation repeated count times in burst
//          mode with busy/done/abort handshake and remaining-count readout.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module univ_shift_reg_burst
  import usr_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            async_rst,
  input  logic            en,
  input  logic [2:0]      mode,
  input  logic            start,
  input  logic [CNTW-1:0] count,
  input  logic            abort,
  input  logic [DW-1:0]   data,
  input  logic            data_l,
  input  logic            data_h,
  output logic [DW-1:0]   q,
  output logic            so_r,
  output logic            so_l,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] rem
);

  localparam logic [CNTW-1:0] C_REM_ONE = CNTW'(1);

  state_t          r_state;
  state_t          w_state_next;
  logic [2:0]      r_op;
  logic [2:0]      w_op_next;
  logic [CNTW-1:0] r_rem;
  logic [CNTW-1:0] w_rem_next;
  logic            r_done;
  logic            w_done_next;
  logic [DW-1:0]   r_q;
  logic            w_q_load;
  logic [2:0]      w_op_sel;
  logic [DW-1:0]   w_q_next;

  // While bursting the latched op drives the datapath; mode is ignored.
  assign w_op_sel = (r_state == ST_BUSY) ? r_op : mode;

  usr_next_val #(
    .DW(DW)
  ) u_next_val (
    .mode   (w_op_sel),
    .q      (r_q),
    .data   (data),
    .data_l (data_l),
    .data_h (data_h),
    .q_next (w_q_next)
  );

  // Next-state, burst bookkeeping and register-update decision.
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_rem_next   = r_rem;
    w_done_next  = 1'b0;
    w_q_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          if (start) begin
            if (count == '0) begin
              // Empty burst completes immediately without touching q.
              w_done_next = 1'b1;
            end else begin
              w_op_next    = mode;
              w_rem_next   = count;
              w_state_next = ST_BUSY;
            end
          end else begin
            w_q_load = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // Abort wins over the enable and skips the operation on this edge.
        if (abort) begin
          w_rem_next   = '0;
          w_state_next = ST_IDLE;
        end else if (en) begin
          w_q_load   = 1'b1;
          w_rem_next = r_rem - C_REM_ONE;
          if (r_rem == C_REM_ONE) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_rem_next   = '0;
      end
    endcase
  end

  // State, burst and data registers with asynchronous clear.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state <= ST_IDLE;
      r_op    <= MODE_HOLD;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_q     <= '0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_rem   <= w_rem_next;
      r_done  <= w_done_next;
      if (w_q_load) begin
        r_q <= w_q_next;
      end
    end
  end

  assign q    = r_q;
  assign so_r = r_q[0];
  assign so_l = r_q[DW-1];
  assign busy = (r_state == ST_BUSY);
  assign done = r_done;
  assign rem  = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg_burst.sv
//------------------------------------------------------------------------------
// Module : tb_univ_shift_reg_burst
// Brief  : Self-checking bench for univ_shift_reg_burst (DW=8, CNTW=4):
//          directed scenarios plus randomized traffic against a behavioural
//          model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_univ_shift_reg_burst;

  localparam int DW   = 8;
  localparam int CNTW = 4;

  logic            clk;
  logic            async_rst;
  logic            en;
  logic [2:0]      mode;
  logic            start;
  logic [CNTW-1:0] count;
  logic            abort;
  logic [DW-1:0]   data;
  logic            data_l;
  logic            data_h;
  logic [DW-1:0]   q;
  logic            so_r;
  logic            so_l;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] rem;

  int n_cmp;
  int n_err;

  // Behavioural model state
  logic [7:0] m_q;
  bit         m_busy;
  int         m_rem;
  logic [2:0] m_op;
  bit         m_done;
  bit         done_seen;

  univ_shift_reg_burst #(
    .DW   (DW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .en        (en),
    .mode      (mode),
    .start     (start),
    .count     (count),
    .abort     (abort),
    .data      (data),
    .data_l    (data_l),
    .data_h    (data_h),
    .q         (q),
    .so_r      (so_r),
    .so_l      (so_l),
    .busy      (busy),
    .done      (done),
    .rem       (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference operation semantics written with plain arithmetic.
  function automatic logic [7:0] ref_next(input logic [2:0] op, input logic [7:0] cur,
                                          input logic [7:0] d, input logic dl, input logic dh);
    int v;
    v = int'(cur);
    case (op)
      3'd0: v = int'(d);
      3'd1: v = (v / 2) + (dh ? 128 : 0);
      3'd2: v = ((v * 2) % 256) + (dl ? 1 : 0);
      3'd3: v = v;
      3'd4: v = (v / 2) + ((v % 2) * 128);
      3'd5: v = ((v * 2) % 256) + (v / 128);
      3'd6: v = (v / 2) + ((v >= 128) ? 128 : 0);
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  task automatic drive(input bit e, input logic [2:0] m, input bit s, input int c,
                       input bit a, input logic [7:0] d, input bit dl, input bit dh);
    en = e; mode = m; start = s; count = CNTW'(c); abort = a;
    data = d; data_l = dl; data_h = dh;
  endtask

  task automatic model_reset();
    m_q = '0; m_busy = 0; m_rem = 0; m_op = 3'd3; m_done = 0;
  endtask

  // Advance the model by one edge using current inputs, then compare all outputs.
  task automatic tick(input string tag);
    logic [7:0] nq;
    bit nd;
    nd = 0;
    nq = m_q;
    if (m_busy) begin
      if (abort) begin
        m_busy = 0;
        m_rem  = 0;
      end else if (en) begin
        nq = ref_next(m_op, m_q, data, data_l, data_h);
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 0;
          nd = 1;
        end
      end
    end else if (en) begin
      if (start) begin
        if (count == 0) nd = 1;
        else begin
          m_op = mode; m_rem = int'(count); m_busy = 1;
        end
      end else begin
        nq = ref_next(mode, m_q, data, data_l, data_h);
      end
    end
    @(posedge clk);
    #1;
    m_q = nq;
    m_done = nd;
    if (done) done_seen = 1;
    check({tag, ".q"},    32'(q),    32'(m_q));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".rem"},  32'(rem),  32'(m_rem));
    check({tag, ".so_r"}, 32'(so_r), 32'(m_q[0]));
    check({tag, ".so_l"}, 32'(so_l), 32'(m_q[7]));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_seen = 0;
    model_reset();
    drive(0, 3'd3, 0, 0, 0, 8'h00, 0, 0);
    async_rst = 1'b1;
    #2;
    check("rst.q",    32'(q),    32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    check("rst.rem",  32'(rem),  32'h0);
    #10 async_rst = 1'b0;

    // Scenario 1: async reset mid-burst without a clock edge
    drive(1, 3'd0, 0, 0, 0, 8'h5A, 0, 0); tick("s1.load");
    drive(1, 3'd3, 1, 3, 0, 8'h00, 0, 0); tick("s1.start");
    drive(1, 3'd3, 0, 0, 0, 8'h00, 0, 0); tick("s1.b1");
    check("s1.q_pre",   32'(q),   32'h5A);
    check("s1.rem_pre", 32'(rem), 32'h2);
    #2 async_rst = 1'b1;
    #1;
    model_reset();
    check("s1.rst_q",    32'(q),    32'h0);
    check("s1.rst_busy", 32'(busy), 32'h0);
    check("s1.rst_rem",  32'(rem),  32'h0);
    #1 async_rst = 1'b0;
    drive(1, 3'd3, 0, 0, 0, 8'h00, 0, 0);
    done_seen = 0;
    repeat (3) tick("s1.after");
    check("s1.no_done", 32'(done_seen), 32'h0);

    // Scenario 2: direct load / hold / clear
    drive(1, 3'd0, 0, 0, 0, 8'hA5, 0, 0); tick("s2.load");
    check("s2.q_load", 32'(q), 32'hA5);
    drive(1, 3'd3, 0, 0, 0, 8'h00, 1, 1);
    repeat (3) tick("s2.hold");
    check("s2.q_hold", 32'(q), 32'hA5);
    drive(1, 3'd7, 0, 0, 0, 8'hFF, 1, 1); tick("s2.clr");
    check("s2.q_clr", 32'(q), 32'h00);

    // Scenario 3: burst rotate right
    drive(1, 3'd0, 0, 0, 0, 8'h81, 0, 0); tick("s3.load");
    drive(1, 3'd4, 1, 3, 0, 8'h00, 0, 0); tick("s3.start");
    check("s3.rem3", 32'(rem), 32'h3);
    drive(1, 3'd0, 0, 0, 0, 8'hFF, 1, 1);
    tick("s3.b1"); check("s3.q1", 32'(q), 32'hC0);
    tick("s3.b2"); check("s3.q2", 32'(q), 32'h60);
    tick("s3.b3"); check("s3.q3", 32'(q), 32'h30);
    check("s3.done", 32'(done), 32'h1);
    check("s3.busy", 32'(busy), 32'h0);

    // Scenario 4: burst arithmetic shift right
    drive(1, 3'd0, 0, 0, 0, 8'h90, 0, 0); tick("s4.load");
    drive(1, 3'd6, 1, 2, 0, 8'h00, 0, 0); tick("s4.start");
    drive(1, 3'd3, 0, 0, 0, 8'h00, 0, 0);
    tick("s4.b1"); check("s4.q1", 32'(q), 32'hC8);
    tick("s4.b2"); check("s4.q2", 32'(q), 32'hE4);
    check("s4.so_r", 32'(so_r), 32'h0);
    check("s4.done", 32'(done), 32'h1);
    tick("s4.after"); check("s4.done_off", 32'(done), 32'h0);

    // Scenario 5: stall and abort
    drive(1, 3'd0, 0, 0, 0, 8'h00, 0, 0); tick("s5.load");
    done_seen = 0;
    drive(1, 3'd2, 1, 4, 0, 8'h00, 1, 0); tick("s5.start");
    drive(1, 3'd3, 0, 0, 0, 8'h00, 1, 0); tick("s5.b1");
    check("s5.q1", 32'(q), 32'h01);
    drive(0, 3'd3, 0, 0, 0, 8'h00, 1, 0);
    repeat (2) tick("s5.stall");
    check("s5.q_stall",    32'(q),    32'h01);
    check("s5.rem_stall",  32'(rem),  32'h3);
    check("s5.busy_stall", 32'(busy), 32'h1);
    drive(1, 3'd3, 0, 0, 0, 8'h00, 1, 0); tick("s5.b2");
    check("s5.q2", 32'(q), 32'h03);
    drive(1, 3'd3, 0, 0, 1, 8'h00, 1, 0); tick("s5.abort");
    check("s5.q_ab",    32'(q),    32'h03);
    check("s5.busy_ab", 32'(busy), 32'h0);
    check("s5.rem_ab",  32'(rem),  32'h0);
    drive(1, 3'd3, 0, 0, 0, 8'h00, 0, 0);
    repeat (2) tick("s5.post");
    check("s5.no_done", 32'(done_seen), 32'h0);

    // Scenario 6: zero-count start, then start ignored during a burst
    drive(1, 3'd1, 1, 0, 0, 8'h00, 1, 1); tick("s6.zero");
    check("s6.q_zero",    32'(q),    32'h03);
    check("s6.done_zero", 32'(done), 32'h1);
    check("s6.busy_zero", 32'(busy), 32'h0);
    drive(1, 3'd5, 1, 3, 0, 8'h00, 0, 0); tick("s6.start");
    drive(1, 3'd0, 1, 7, 0, 8'hEE, 0, 0);
    tick("s6.b1"); check("s6.q1", 32'(q), 32'h06);
    tick("s6.b2"); check("s6.q2", 32'(q), 32'h0C);
    tick("s6.b3"); check("s6.q3", 32'(q), 32'h18);
    // New start accepted on the done cycle
    drive(1, 3'd4, 1, 1, 0, 8'h00, 0, 0); tick("s6.restart");
    check("s6.busy_re", 32'(busy), 32'h1);
    drive(1, 3'd3, 0, 0, 0, 8'h00, 0, 0); tick("s6.re_b1");
    check("s6.q_re", 32'(q), 32'h0C);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0,
            ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15)),
            $urandom_range(0, 19) == 0, 8'($urandom),
            1'($urandom), 1'($urandom));
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
